// File: rtl/orange_sprite_fetch_if.sv
// Bundle of scan, frame-position, sprite-ROM and palette-side signals for orange_sprite_fetch.
// master = the video system around the block, slave = orange_sprite_fetch itself.
interface orange_sprite_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              frame_start;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic              visible;
  logic              flip_h;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        index_out;
  logic              pixel_valid;

  modport master (
    output frame_start, DrawX, DrawY, pos_x, pos_y, visible, flip_h, rom_data,
    input  rom_addr, index_out, pixel_valid
  );

  modport slave (
    input  frame_start, DrawX, DrawY, pos_x, pos_y, visible, flip_h, rom_data,
    output rom_addr, index_out, pixel_valid
  );
endinterface

// File: rtl/orange_sprite_fetch.sv
// Orange sprite pixel fetch: hit test, ROM addressing and palette-index output, 3-cycle latency.
// Optional horizontal mirroring is built only when ORANGE_FLIP_EN is defined.
module orange_sprite_fetch #(
  parameter int         SPR_W      = 64,
  parameter int         SPR_H      = 64,
  parameter logic [7:0] TRANSP_IDX = 8'd1,
  parameter int         ADDR_W     = $clog2(SPR_W*SPR_H)
) (
  input logic                Clk,
  input logic                Reset,
  orange_sprite_fetch_if.slave bus
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam logic signed [11:0] SPR_W_S = 12'(SPR_W);
  localparam logic signed [11:0] SPR_H_S = 12'(SPR_H);

  logic [10:0]       pos_x_q, pos_y_q;
  logic              vis_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d2_q;
  logic [7:0]        index_q;
  logic              valid_q;

  logic signed [11:0] dx, dy;
  logic               hit;
  logic [XW-1:0]      col;

  // Shadow copies: everything in the hit test comes from here so a frame never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      vis_q   <= 1'b0;
    end else if (bus.frame_start) begin
      pos_x_q <= bus.pos_x;
      pos_y_q <= bus.pos_y;
      vis_q   <= bus.visible;
    end
  end

`ifdef ORANGE_FLIP_EN
  logic flip_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flip_q <= 1'b0;
    end else if (bus.frame_start) begin
      flip_q <= bus.flip_h;
    end
  end
`else
  logic unused_flip_h;
  assign unused_flip_h = bus.flip_h;
`endif

  // Signed offsets let partly off-screen sprites clip without any wrap-around aliasing
  always_comb begin
    dx  = $signed({2'b00, bus.DrawX}) - $signed({pos_x_q[10], pos_x_q});
    dy  = $signed({2'b00, bus.DrawY}) - $signed({pos_y_q[10], pos_y_q});
    hit = vis_q & ~dx[11] & (dx < SPR_W_S) & ~dy[11] & (dy < SPR_H_S);
    col = dx[XW-1:0];
`ifdef ORANGE_FLIP_EN
    if (flip_q) begin
      col = ~dx[XW-1:0];
    end
`endif
    rom_addr_d = rom_addr_q;
    if (hit) begin
      rom_addr_d = ADDR_W'({dy[YW-1:0], col});
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= '0;
      hit_d1_q   <= 1'b0;
      hit_d2_q   <= 1'b0;
      index_q    <= 8'd0;
      valid_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_d1_q   <= hit;
      hit_d2_q   <= hit_d1_q;
      index_q    <= hit_d2_q ? bus.rom_data : 8'd0;
      valid_q    <= hit_d2_q & (bus.rom_data != TRANSP_IDX);
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.index_out   = index_q;
  assign bus.pixel_valid = valid_q;

endmodule

// File: tb/tb_orange_sprite_fetch.sv
// Self-checking bench for orange_sprite_fetch: directed vector table, hand sequences for
// frame-latch and reset corners, then random scanning against a geometric reference model.
module tb_orange_sprite_fetch;

  localparam int SPR_W  = 64;
  localparam int SPR_H  = 64;
  localparam int ADDR_W = 12;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  orange_sprite_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  orange_sprite_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .TRANSP_IDX(8'd1), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  logic [7:0] rom [0:SPR_W*SPR_H-1];
  always @(posedge Clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    int idx;
    bit valid;
  } exp_t;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    bit          vis;
    bit          flip;
    logic [9:0]  x;
    logic [9:0]  y;
    bit          expHit;
    int          expAddr;
  } vec_t;

  int   compared;
  int   mismatched;
  int   shX, shY;
  bit   shVis, shFlip;
  int   modelAddr;
  exp_t expQ[$];
  vec_t vecs[8];

  function automatic int sext11(input logic [10:0] v);
    return int'(signed'(v));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit fs, input int x, input int y, input int px,
                               input int py, input bit vis, input bit flip);
    bus.frame_start = fs;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.pos_x       = 11'(px);
    bus.pos_y       = 11'(py);
    bus.visible     = vis;
    bus.flip_h      = flip;
  endtask

  // Geometric view: pixel offset from the latched top-left corner, row-major address
  task automatic predict(output bit hit, output int addr);
    int x, y, c;
    x   = int'(bus.DrawX) - shX;
    y   = int'(bus.DrawY) - shY;
    hit = shVis && x >= 0 && x < SPR_W && y >= 0 && y < SPR_H;
    c   = x;
`ifdef ORANGE_FLIP_EN
    if (shFlip) c = SPR_W - 1 - x;
`endif
    addr = y * SPR_W + c;
  endtask

  task automatic step();
    bit   hit, fs, vis, flip;
    int   addr, px, py;
    exp_t e;
    predict(hit, addr);
    e.idx   = hit ? int'(rom[addr]) : 0;
    e.valid = hit && (rom[addr] != 8'd1);
    expQ.push_back(e);
    fs   = bus.frame_start;
    px   = sext11(bus.pos_x);
    py   = sext11(bus.pos_y);
    vis  = bus.visible;
    flip = bus.flip_h;
    @(posedge Clk);
    #1;
    if (hit) modelAddr = addr;
    if (fs) begin
      shX = px; shY = py; shVis = vis; shFlip = flip;
    end
    e = expQ.pop_front();
    checkOutput("rom_addr", int'(bus.rom_addr), modelAddr);
    checkOutput("index_out", int'(bus.index_out), e.idx);
    checkOutput("pixel_valid", int'(bus.pixel_valid), int'(e.valid));
  endtask

  task automatic doReset();
    exp_t z;
    Reset = 1'b1;
    #1;
    checkOutput("reset index_out", int'(bus.index_out), 0);
    checkOutput("reset pixel_valid", int'(bus.pixel_valid), 0);
    checkOutput("reset rom_addr", int'(bus.rom_addr), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    shX = 0; shY = 0; shVis = 1'b0; shFlip = 1'b0;
    modelAddr = 0;
    expQ.delete();
    z.idx = 0;
    z.valid = 1'b0;
    expQ.push_back(z);
    expQ.push_back(z);
  endtask

  initial begin
    int x, y;
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < SPR_W*SPR_H; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'($urandom);
    rom[0]    = 8'h5A;
    rom[10]   = 8'd1;
    rom[650]  = 8'h77;
    rom[1280] = 8'h3C;
    rom[1895] = 8'hE1;
    rom[4095] = 8'hC3;

    vecs[0] = '{11'd100, 11'd50, 1'b1, 1'b0, 10'd100, 10'd50, 1'b1, 0};
    vecs[1] = '{11'd100, 11'd50, 1'b1, 1'b0, 10'd163, 10'd113, 1'b1, 4095};
    vecs[2] = '{11'd100, 11'd50, 1'b1, 1'b0, 10'd164, 10'd50, 1'b0, 0};
    vecs[3] = '{11'h7F6, 11'd50, 1'b1, 1'b0, 10'd0, 10'd50, 1'b1, 10};
    vecs[4] = '{11'h7F6, 11'd50, 1'b1, 1'b0, 10'd54, 10'd50, 1'b0, 0};
    vecs[5] = '{11'd5, 11'h7EC, 1'b1, 1'b0, 10'd5, 10'd0, 1'b1, 1280};
    vecs[6] = '{11'd600, 11'd450, 1'b0, 1'b0, 10'd639, 10'd479, 1'b0, 0};
`ifdef ORANGE_FLIP_EN
    vecs[7] = '{11'd0, 11'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 63};
`else
    vecs[7] = '{11'd0, 11'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 0};
`endif

    applyStimulus(1'b0, 0, 479, 0, 0, 1'b1, 1'b0);
    doReset();

    foreach (vecs[i]) begin
      applyStimulus(1'b1, 0, 479, sext11(vecs[i].px), sext11(vecs[i].py), vecs[i].vis, vecs[i].flip);
      step();
      applyStimulus(1'b0, vecs[i].x, vecs[i].y, sext11(vecs[i].px), sext11(vecs[i].py), vecs[i].vis, vecs[i].flip);
      step();
      if (vecs[i].expHit)
        checkOutput($sformatf("vec%0d rom_addr", i), int'(bus.rom_addr), vecs[i].expAddr);
      applyStimulus(1'b0, 0, 479, sext11(vecs[i].px), sext11(vecs[i].py), vecs[i].vis, vecs[i].flip);
      step();
      step();
      checkOutput($sformatf("vec%0d index_out", i), int'(bus.index_out),
                  vecs[i].expHit ? int'(rom[vecs[i].expAddr]) : 0);
      checkOutput($sformatf("vec%0d pixel_valid", i), int'(bus.pixel_valid),
                  int'(vecs[i].expHit && rom[vecs[i].expAddr] != 8'd1));
    end
    // Unmirrored, visible sprite at the origin before the frame_start corner
    applyStimulus(1'b1, 0, 479, 0, 0, 1'b1, 1'b0);
    step();

    // frame_start coinciding with a pixel: that pixel still sees the old position
    applyStimulus(1'b1, 10, 10, 300, 300, 1'b1, 1'b0);
    step();
    checkOutput("fs same-cycle rom_addr", int'(bus.rom_addr), 650);
    applyStimulus(1'b0, 10, 10, 300, 300, 1'b1, 1'b0);
    step();
    checkOutput("fs next-cycle addr hold", int'(bus.rom_addr), 650);
    applyStimulus(1'b0, 0, 479, 300, 300, 1'b1, 1'b0);
    step();
    checkOutput("fs same-cycle index_out", int'(bus.index_out), 8'h77);
    step();
    checkOutput("fs next-cycle pixel_valid", int'(bus.pixel_valid), 0);

    // frame_start held for several cycles: only the last captured position counts
    applyStimulus(1'b1, 0, 479, 200, 100, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 0, 479, 250, 120, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 0, 479, 320, 200, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 320, 200, 320, 200, 1'b1, 1'b0);
    step();
    checkOutput("held fs corner rom_addr", int'(bus.rom_addr), 0);
    applyStimulus(1'b0, 383, 263, 320, 200, 1'b1, 1'b0);
    step();
    checkOutput("held fs far corner rom_addr", int'(bus.rom_addr), 4095);

    // Reset while hits are streaming, then stay dark until the next frame_start
    applyStimulus(1'b0, 330, 210, 320, 200, 1'b1, 1'b0);
    step();
    step();
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 320 + i, 200, 320, 200, 1'b1, 1'b0);
      step();
      checkOutput("post-reset pixel_valid", int'(bus.pixel_valid), 0);
    end

    // Random scanning with sporadic frame latches and resets
    for (int n = 0; n < 3000; n++) begin
      bit fs;
      fs = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        x = shX + int'($urandom_range(0, 80)) - 8;
        y = shY + int'($urandom_range(0, 80)) - 8;
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      applyStimulus(fs, x, y, int'($urandom_range(0, 800)) - 100, int'($urandom_range(0, 600)) - 100,
                    $urandom_range(0, 3) != 0, 1'($urandom));
      step();
      if ($urandom_range(0, 999) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/orange_sprite_fetch.md
# orange_sprite_fetch

Upstream pixel stage for the orange sprite. Each clock it takes the VGA scan position and the orange's on-screen position, and decides whether the pixel falls inside the sprite. When it does, it reads the sprite ROM and passes the 8-bit colour index to the orange palette lookup, together with a per-pixel valid flag. Position, visibility and flip are latched once per frame, so a sprite never tears mid-frame.

## Interface
Parameters:
- SPR_W, 64, sprite width in pixels (power of two, 8–128)
- SPR_H, 64, sprite height in pixels (power of two, 8–128)
- TRANSP_IDX, 8'd1, palette index treated as transparent
- ADDR_W, $clog2(SPR_W*SPR_H), ROM address width

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- DrawX  in  10  current scan column, 0–639
- DrawY  in  10  current scan row, 0–479
- pos_x  in  11  sprite top-left column, two's complement
- pos_y  in  11  sprite top-left row, two's complement
- visible  in  1  orange exists this frame
- flip_h  in  1  horizontal mirror request (used only with ORANGE_FLIP_EN)
- rom_addr  out  ADDR_W  sprite ROM read address; ROM is synchronous with 1-cycle latency
- rom_data  in  8  ROM read data
- index_out  out  8  palette index forwarded to the palette stage
- pixel_valid  out  1  1 = opaque sprite pixel in index_out

## Operation
- Frame latch: on a cycle with frame_start=1, capture pos_x, pos_y, visible and flip_h into shadow registers. All hit tests use only the shadow values.
- Stage 0, combinational then registered:
  - dx = {2'b0,DrawX} − sext(pos_x) and dy = {2'b0,DrawY} − sext(pos_y), both 12-bit signed.
  - hit = shadow_visible & 0≤dx<SPR_W & 0≤dy<SPR_H.
  - rom_addr = {dy[log2 SPR_H−1:0], dx[log2 SPR_W−1:0]}, registered.
  - hit is registered into hit_d1.
  - When hit=0, rom_addr holds its previous value; no ROM access is needed.
- Stage 1: the ROM returns rom_data; hit_d1 is delayed to hit_d2.
- Stage 2, registered outputs:
  - index_out = rom_data when hit_d2, else 8'd0.
  - pixel_valid = hit_d2 & (rom_data ≠ TRANSP_IDX).
- Sprites partly off-screen, including negative pos_x/pos_y, clip naturally through the signed compare. An off-screen area is never addressed.
- There is no wrap-around: dx ≥ SPR_W never aliases into the sprite.

## Timing
- Reset, asynchronous, takes effect immediately:
  - rom_addr=0, index_out=0, pixel_valid=0.
  - hit_d1 and hit_d2 = 0.
  - Shadow registers: pos=0, visible=0, flip=0.
- Latency is 3 clocks from a DrawX/DrawY sample to its index_out/pixel_valid:
  - register to rom_addr
  - ROM read
  - output register
- Downstream must delay DrawX/DrawY by 3 to stay aligned.
- Throughput is one pixel per clock with no stalls; there is no handshake beyond frame_start.
- frame_start in the same cycle as a pixel: that pixel uses the old shadow values. The new values apply from the next cycle.
- Reset deasserted mid-frame: outputs stay 0 until the first frame_start, because shadow_visible=0.
- frame_start held high for several cycles: the shadow values track the inputs every cycle. Only the last cycle matters.

## Configuration
- ORANGE_FLIP_EN defined:
  - When the shadow flip is 1, the column term is (SPR_W−1−dx).
  - The hit test and latency are unchanged.
- ORANGE_FLIP_EN undefined:
  - flip_h is ignored and no flip register is built.
  - The column term is always dx.

## Test plan
- Reset mid-stream with visible=1 → index_out=0 and pixel_valid=0 in the same cycle. Both stay 0 until frame_start.
- pos=(100,50), visible=1, frame_start, scan (100,50) → rom_addr=0 one clock later. index_out equals ROM[0] three clocks after the sample. pixel_valid=1 if ROM[0]≠1.
- Same position, scan (163,113) → rom_addr=4095. Scan (164,50) → pixel_valid=0 and index_out=0 three clocks later.
- pos_x=−10 (11'h7F6), scan DrawX=0 at the sprite's top row → rom_addr=10, hit=1. DrawX=54 → hit=0.
- ROM word equal to 8'd1 inside the sprite → index_out=1 and pixel_valid=0.
- With ORANGE_FLIP_EN, flip_h=1, pos=(0,0), scan (0,0) → rom_addr=63. Without the macro the same stimulus gives rom_addr=0.
